cpu_bus_bridge_mp: RTL and testbench

Parametrised multi-channel bridge from CPU-side request channels (imem, dmem, debug, DMA-coherent port, ...) to one VTX1 bus matrix master port. Requests are arbitrated round-robin and fields are latched at grant, so exactly one bus transaction is outstanding at a time. A programmable timeout and bounded automatic retry apply to every transaction. Per-channel completion and error pulses are returned, plus transaction, error and retry statistics. Sits between the CPU core and the bus matrix.

---
 rtl/cpu_bus_bridge_mp.sv | 194 +++++++++++++++++++
 tb/tb_cpu_bus_bridge_mp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_bridge_mp.sv
// Multi-channel CPU request bridge onto a single VTX1 bus master port.
// Round-robin grant, one outstanding transaction, local timeout and bounded retry.

module cpu_bus_bridge_mp_ch (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic set_done,
  input  logic set_err,
  output logic done,
  output logic err,
  output logic elig
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= set_done;
      err  <= set_err;
    end
  end

  // A requester still holding req during its completion pulse is not re-eligible.
  assign elig = req & ~done;
endmodule

module cpu_bus_bridge_mp #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 2,
  parameter int TMO_W     = 4,
  parameter int TMO_MAX   = 15,
  parameter int MAX_RETRY = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_wr,
  input  logic [NUM_CH-1:0][1:0]         ch_size,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]              ch_done,
  output logic [NUM_CH-1:0]              ch_err,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic                           bus_req,
  output logic                           bus_wr,
  output logic [1:0]                     bus_size,
  output logic [ADDR_W-1:0]              bus_addr,
  output logic [DATA_W-1:0]              bus_wdata,
  input  logic [DATA_W-1:0]              bus_rdata,
  input  logic                           bus_ready,
  input  logic                           bus_error,
  input  logic                           bus_timeout,
  input  logic [3:0]                     bus_error_code,
  output logic                           bus_error_clear,
  output logic [1:0]                     bridge_state,
  output logic [2:0]                     grant_id,
  output logic [31:0]                    txn_count,
  output logic [15:0]                    error_count,
  output logic [15:0]                    retry_count,
  output logic [3:0]                     last_err_code
);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RECOVER = 2'd2, S_BAD = 2'd3} state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        id;
  } req_t;

  localparam req_t LAT_RST = '{wr: 1'b0, size: 2'b10, addr: '0, wdata: '0, id: 3'd0};

  state_t            state, nxt;
  req_t              lat, sel;
  logic [2:0]        ptr, nxt_ptr;
  logic [3:0]        rr_idx;
  logic [7:0]        elig_x;
  logic [TMO_W-1:0]  timer;
  logic [RW-1:0]     tries;
  logic [NUM_CH-1:0] elig, set_done, set_err;
  logic              grant, ok, fail, can_retry, give_up, tmo_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign set_done[gi] = (ok | give_up) && (lat.id == 3'(gi));
      assign set_err[gi]  = give_up && (lat.id == 3'(gi));
      cpu_bus_bridge_mp_ch u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (ch_req[gi]),
        .set_done (set_done[gi]),
        .set_err  (set_err[gi]),
        .done     (ch_done[gi]),
        .err      (ch_err[gi]),
        .elig     (elig[gi])
      );
    end
  endgenerate

  // Scan downward so the last hit is the first eligible channel at or after ptr.
  always_comb begin
    elig_x = '0;
    elig_x[NUM_CH-1:0] = elig;
    grant  = 1'b0;
    rr_idx = '0;
    sel    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      rr_idx = {1'b0, ptr} + 4'(i);
      if (rr_idx >= 4'(NUM_CH)) rr_idx = rr_idx - 4'(NUM_CH);
      if (elig_x[rr_idx[2:0]]) begin
        grant  = 1'b1;
        sel.id = rr_idx[2:0];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel.id == 3'(i)) begin
        sel.wr    = ch_wr[i];
        sel.size  = ch_size[i];
        sel.addr  = ch_addr[i];
        sel.wdata = ch_wdata[i];
      end
    end
    nxt_ptr = (({1'b0, sel.id} + 4'd1) >= 4'(NUM_CH)) ? 3'd0 : sel.id + 3'd1;
  end

  assign tmo_hit   = (timer == TMO_W'(TMO_MAX));
  assign can_retry = (int'(tries) < MAX_RETRY);
  assign give_up   = fail & ~can_retry;

  // An error or bus timeout outranks a coincident ready.
  always_comb begin
    nxt  = state;
    ok   = 1'b0;
    fail = 1'b0;
    case (state)
      S_IDLE: if (grant) nxt = S_WAIT;
      S_WAIT: begin
        if (bus_error | bus_timeout) fail = 1'b1;
        else if (bus_ready)          ok   = 1'b1;
        else if (tmo_hit)            fail = 1'b1;
        if (ok)        nxt = S_IDLE;
        else if (fail) nxt = can_retry ? S_RECOVER : S_IDLE;
      end
      S_RECOVER: nxt = S_WAIT;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ptr           <= '0;
      lat           <= LAT_RST;
      timer         <= '0;
      tries         <= '0;
      ch_rdata      <= '0;
      txn_count     <= '0;
      error_count   <= '0;
      retry_count   <= '0;
      last_err_code <= '0;
    end else begin
      state <= nxt;
      timer <= (state == S_WAIT) ? timer + 1'b1 : '0;
      if (state == S_IDLE && grant) begin
        lat   <= sel;
        ptr   <= nxt_ptr;
        tries <= '0;
      end else if (fail && can_retry) begin
        tries <= tries + 1'b1;
      end
      if (fail && can_retry && retry_count != 16'hFFFF) retry_count <= retry_count + 16'd1;
      if (ok | give_up) txn_count <= txn_count + 32'd1;
      if (give_up && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
      if (state == S_WAIT && bus_error)  last_err_code <= bus_error_code;
      else if (fail && !bus_timeout)     last_err_code <= 4'hF;
      ch_rdata <= (ok && !lat.wr) ? bus_rdata : '0;
    end
  end

  assign bus_req         = (state == S_WAIT);
  assign bus_error_clear = (state == S_RECOVER);
  assign bus_wr          = lat.wr;
  assign bus_size        = lat.size;
  assign bus_addr        = lat.addr;
  assign bus_wdata       = lat.wdata;
  assign grant_id        = lat.id;
  assign bridge_state    = state;
endmodule

// File: tb/tb_cpu_bus_bridge_mp.sv
// Directed and randomized bench for cpu_bus_bridge_mp; the bench plays the bus
// slave and predicts outcomes per transaction from attempt plans.

module tb_cpu_bus_bridge_mp;
  localparam int ADDR_W = 32, DATA_W = 32, NUM_CH = 2, TMO_W = 4, TMO_MAX = 15, MAX_RETRY = 2;
  localparam int K_OK = 0, K_ERR = 1, K_COLL = 2, K_BTMO = 3, K_NONE = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_CH-1:0]             ch_req, ch_wr, ch_done, ch_err;
  logic [NUM_CH-1:0][1:0]        ch_size;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_wdata;
  logic [DATA_W-1:0]             ch_rdata, bus_wdata, bus_rdata;
  logic                          bus_req, bus_wr, bus_ready, bus_error, bus_timeout, bus_error_clear;
  logic [1:0]                    bus_size, bridge_state;
  logic [ADDR_W-1:0]             bus_addr;
  logic [3:0]                    bus_error_code, last_err_code;
  logic [2:0]                    grant_id;
  logic [31:0]                   txn_count;
  logic [15:0]                   error_count, retry_count;

  int errors = 0, checks = 0;
  int txn_m = 0, err_m = 0, retry_m = 0, ptr_m = 0;
  logic [3:0] code_m = 4'h0;
  int plan_kind [8];
  int plan_lat  [8];
  logic [3:0] plan_code [8];

  cpu_bus_bridge_mp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .TMO_W(TMO_W),
                      .TMO_MAX(TMO_MAX), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_done(ch_done), .ch_err(ch_err),
    .ch_rdata(ch_rdata), .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .bus_error(bus_error), .bus_timeout(bus_timeout),
    .bus_error_code(bus_error_code), .bus_error_clear(bus_error_clear),
    .bridge_state(bridge_state), .grant_id(grant_id), .txn_count(txn_count),
    .error_count(error_count), .retry_count(retry_count), .last_err_code(last_err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 8; i++) begin
      plan_kind[i] = K_OK;
      plan_lat[i]  = 0;
      plan_code[i] = 4'h0;
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_txn"},   txn_count,     txn_m);
    chk({tag, "_err"},   error_count,   err_m);
    chk({tag, "_retry"}, retry_count,   retry_m);
    chk({tag, "_code"},  last_err_code, code_m);
  endtask

  // One transaction on a single channel, following plan_* attempt by attempt.
  task automatic txn(input int ch, input logic wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rd);
    int L;
    bit success;
    logic [NUM_CH-1:0] exp_done;
    logic [DATA_W-1:0] exp_rd;
    success = 1'b0;
    @(negedge clk);
    chk("idle_state", bridge_state, 0);
    chk("idle_busreq", bus_req, 0);
    ch_req = '0;
    ch_req[ch] = 1'b1; ch_wr[ch] = wr; ch_size[ch] = 2'b10;
    ch_addr[ch] = addr; ch_wdata[ch] = wdata;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      L = (plan_kind[a] == K_NONE) ? TMO_MAX : plan_lat[a];
      for (int c = 0; c <= L; c++) begin
        @(negedge clk);
        chk("wait_req", bus_req, 1);
        chk("wait_state", bridge_state, 1);
        chk("wait_clr", bus_error_clear, 0);
        chk("wait_gid", grant_id, ch);
        chk("wait_addr", bus_addr, addr);
        chk("wait_wr", bus_wr, wr);
        chk("wait_wdata", bus_wdata, wdata);
        chk("wait_size", bus_size, 2);
        chk("wait_done", ch_done, 0);
        if (a == 0 && c == 0) begin
          ch_wr[ch] = ~wr; ch_size[ch] = 2'b01; ch_addr[ch] = ~addr; ch_wdata[ch] = ~wdata;
        end
        bus_rdata = $urandom;
        bus_error_code = 4'($urandom);
        if (c == L) begin
          case (plan_kind[a])
            K_OK:    begin bus_ready = 1'b1; bus_rdata = rd; end
            K_ERR:   begin bus_error = 1'b1; bus_error_code = plan_code[a]; end
            K_COLL:  begin bus_ready = 1'b1; bus_error = 1'b1; bus_error_code = plan_code[a]; end
            K_BTMO:  bus_timeout = 1'b1;
            default: ;
          endcase
        end
      end
      @(negedge clk);
      bus_ready = 1'b0; bus_error = 1'b0; bus_timeout = 1'b0;
      if (plan_kind[a] == K_OK) begin
        success = 1'b1;
        break;
      end
      if (plan_kind[a] == K_ERR || plan_kind[a] == K_COLL) code_m = plan_code[a];
      else if (plan_kind[a] == K_NONE) code_m = 4'hF;
      if (a < MAX_RETRY) begin
        retry_m++;
        chk("rec_req", bus_req, 0);
        chk("rec_state", bridge_state, 2);
        chk("rec_clr", bus_error_clear, 1);
        chk("rec_done", ch_done, 0);
      end
    end
    txn_m++;
    if (!success) err_m++;
    exp_done = '0;
    exp_done[ch] = 1'b1;
    exp_rd = wr ? '0 : rd;
    chk("done_vec", ch_done, exp_done);
    chk("done_err", ch_err, success ? '0 : exp_done);
    if (success) chk("done_rdata", ch_rdata, exp_rd);
    chk("done_busreq", bus_req, 0);
    chk_counters("done");
    ch_req[ch] = 1'b0;
    ptr_m = (ch + 1) % NUM_CH;
    @(negedge clk);
    chk("pulse_done", ch_done, 0);
    chk("pulse_err", ch_err, 0);
  endtask

  initial begin
    int k, exp_g, nf, r;
    logic [NUM_CH-1:0] exp_done;
    rst_n = 1'b0;
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
    bus_rdata = '0; bus_ready = 1'b0; bus_error = 1'b0; bus_timeout = 1'b0; bus_error_code = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_size", bus_size, 2);
    chk("rst_wr", bus_wr, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_state", bridge_state, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_done", ch_done, 0);
    chk("rst_rdata", ch_rdata, 0);
    chk("rst_clr", bus_error_clear, 0);
    chk_counters("rst");
    rst_n = 1'b1;

    // Single read, ready on the fourth WAIT cycle.
    clear_plan();
    plan_lat[0] = 3;
    txn(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);

    // Error code 3 then success.
    clear_plan();
    plan_kind[0] = K_ERR; plan_lat[0] = 1; plan_code[0] = 4'h3;
    plan_lat[1] = 2;
    txn(1, 1'b0, 32'h204, 32'h0, 32'h12345678);

    // Bus never answers: three full timeouts, then failure.
    clear_plan();
    plan_kind[0] = K_NONE; plan_kind[1] = K_NONE; plan_kind[2] = K_NONE;
    txn(0, 1'b1, 32'h300, 32'hCAFEF00D, 32'h0);

    // Ready and error together count as an error.
    clear_plan();
    plan_kind[0] = K_COLL; plan_code[0] = 4'h9;
    txn(1, 1'b1, 32'h404, 32'h55AA55AA, 32'h0);

    // Both channels requesting continuously on a one-cycle bus.
    for (int c = 0; c < NUM_CH; c++) begin
      ch_wr[c] = 1'b0; ch_size[c] = 2'b10; ch_addr[c] = 32'h2000 + 32'(c) * 4;
    end
    ch_req = '1;
    bus_ready = 1'b1;
    exp_g = ptr_m;
    for (int g = 0; g < 6; g++) begin
      k = 0;
      while (!bus_req && k < 4) begin
        @(negedge clk);
        k++;
      end
      chk("fair_req", bus_req, 1);
      chk("fair_gid", grant_id, exp_g);
      chk("fair_addr", bus_addr, 32'h2000 + 32'(exp_g) * 4);
      @(negedge clk);
      exp_done = '0;
      exp_done[exp_g] = 1'b1;
      chk("fair_done", ch_done, exp_done);
      txn_m++;
      if (g == 5) begin
        ch_req = '0;
        bus_ready = 1'b0;
      end
      exp_g = (exp_g + 1) % NUM_CH;
      ptr_m = exp_g;
    end
    chk("fair_txn", txn_count, txn_m);

    // Randomized transactions with random failure plans.
    for (int t = 0; t < 30; t++) begin
      nf = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) begin
        plan_kind[i] = K_OK;
        plan_lat[i]  = $urandom_range(0, 8);
        plan_code[i] = 4'($urandom);
      end
      for (int i = 0; i < nf; i++) begin
        r = $urandom_range(0, 7);
        plan_kind[i] = (r < 3) ? K_ERR : (r < 5) ? K_COLL : (r < 7) ? K_BTMO : K_NONE;
      end
      txn($urandom_range(0, NUM_CH - 1), 1'($urandom), $urandom, $urandom, $urandom);
    end

    // Reset in the middle of a WAIT with the pointer sitting at channel 1.
    @(negedge clk);
    ch_req = '0; ch_req[0] = 1'b1; ch_wr[0] = 1'b0; ch_addr[0] = 32'h500;
    @(negedge clk);
    chk("mid_req", bus_req, 1);
    chk("mid_gid", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus_req, 0);
    chk("mid_rst_state", bridge_state, 0);
    chk("mid_rst_done", ch_done, 0);
    txn_m = 0; err_m = 0; retry_m = 0; code_m = 4'h0; ptr_m = 0;
    chk_counters("mid_rst");
    ch_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", ch_done, 0);
    chk("post_rst_req", bus_req, 0);
    ch_req = '1;
    ch_addr[1] = 32'h604;
    @(negedge clk);
    chk("post_rst_busreq", bus_req, 1);
    chk("post_rst_gid", grant_id, 0);
    chk("post_rst_addr", bus_addr, 32'h500);
    bus_ready = 1'b1;
    bus_rdata = 32'hA5A5_0001;
    @(negedge clk);
    bus_ready = 1'b0;
    ch_req = '0;
    txn_m++;
    chk("post_rst_dvec", ch_done, 1);
    chk("post_rst_rdata", ch_rdata, 32'hA5A5_0001);
    chk_counters("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
